// File: rtl/lcd_status_reader.sv
// lcd_status_reader: reads the HD44780 busy flag (BF) and address counter (AC)
// over the 4-bit LCD bus (RS=0, RW=1, two E strobes, high nibble first).
// Optionally repeats the read until BF clears, or until MAX_POLLS reads.
//
// Ports:
//   clk        clock (clk_disp domain)
//   rst        asynchronous active-low reset
//   start      request a read; sampled only while idle
//   poll       sampled with start; 1 = repeat reads until BF=0
//   ready      1 while idle
//   done       one-cycle pulse when a transaction ends
//   busy_flag  last BF read (held until the next done; 1 after reset)
//   addr_cnt   last AC read (held until the next done)
//   timeout    valid with done; poll gave up with BF still 1
//   bus_owned  1 from setup through hold; top must tristate LCDDAT
//   lcd_e      LCD enable
//   lcd_rs     LCD register select (status register, always 0)
//   lcd_rw     LCD read/write, high while the bus is owned
//   lcd_dat_i  LCD data bus, read direction
module lcd_status_reader #(
  parameter int unsigned SETUP_CYC  = 3,
  parameter int unsigned E_HIGH_CYC = 12,
  parameter int unsigned E_LOW_CYC  = 13,
  parameter int unsigned HOLD_CYC   = 1,
  parameter int unsigned MAX_POLLS  = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       poll,
  output logic       ready,
  output logic       done,
  output logic       busy_flag,
  output logic [6:0] addr_cnt,
  output logic       timeout,
  output logic       bus_owned,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  input  logic [3:0] lcd_dat_i
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned POLL_W = 8;

  localparam logic [CNT_W-1:0]  SETUP_LD  = CNT_W'(SETUP_CYC);
  localparam logic [CNT_W-1:0]  EHI_LD    = CNT_W'(E_HIGH_CYC);
  localparam logic [CNT_W-1:0]  ELO_LD    = CNT_W'(E_LOW_CYC);
  localparam logic [CNT_W-1:0]  HOLD_LD   = CNT_W'(HOLD_CYC);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(MAX_POLLS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_E1_HI,
    S_E1_LO,
    S_E2_HI,
    S_E2_LO,
    S_HOLD,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [POLL_W-1:0] poll_cnt_q, poll_cnt_d;
  logic              poll_q, poll_d;
  // {BF, AC[6:0]} as assembled from the two strobes of the current read
  logic [7:0]        cap_q, cap_d;

  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              busy_flag_q, busy_flag_d;
  logic [6:0]        addr_cnt_q, addr_cnt_d;
  logic              timeout_q, timeout_d;
  logic              bus_owned_q, bus_owned_d;
  logic              lcd_e_q, lcd_e_d;
  logic              last_c;

  // Next-state, counter, capture and registered-output decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
    poll_cnt_d  = poll_cnt_q;
    poll_d      = poll_q;
    cap_d       = cap_q;
    last_c      = (cnt_q == CNT_W'(1));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_SETUP;
          cnt_d      = SETUP_LD;
          poll_d     = poll;
          poll_cnt_d = '0;
        end
      end
      S_SETUP: begin
        if (last_c) begin
          state_d = S_E1_HI;
          cnt_d   = EHI_LD;
        end
      end
      S_E1_HI: begin
        if (last_c) begin
          cap_d[7:4] = lcd_dat_i;
          state_d    = S_E1_LO;
          cnt_d      = ELO_LD;
        end
      end
      S_E1_LO: begin
        if (last_c) begin
          state_d = S_E2_HI;
          cnt_d   = EHI_LD;
        end
      end
      S_E2_HI: begin
        if (last_c) begin
          cap_d[3:0] = lcd_dat_i;
          state_d    = S_E2_LO;
          cnt_d      = ELO_LD;
        end
      end
      S_E2_LO: begin
        if (last_c) begin
          // Re-read straight into the next strobe pair; RW stays high
          if (poll_q && cap_q[7] && (poll_cnt_q < POLL_LAST)) begin
            poll_cnt_d = poll_cnt_q + POLL_W'(1);
            state_d    = S_E1_HI;
            cnt_d      = EHI_LD;
          end else begin
            state_d = S_HOLD;
            cnt_d   = HOLD_LD;
          end
        end
      end
      S_HOLD: begin
        if (last_c) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d     = (state_d == S_IDLE);
    done_d      = (state_d == S_DONE);
    bus_owned_d = (state_d inside {S_SETUP, S_E1_HI, S_E1_LO, S_E2_HI, S_E2_LO, S_HOLD});
    lcd_e_d     = (state_d inside {S_E1_HI, S_E2_HI});
    busy_flag_d = (state_d == S_DONE) ? cap_d[7]   : busy_flag_q;
    addr_cnt_d  = (state_d == S_DONE) ? cap_d[6:0] : addr_cnt_q;
    timeout_d   = (state_d == S_DONE) && poll_q && cap_d[7] && (poll_cnt_q == POLL_LAST);
  end

  // State and output registers; reset aborts any transaction without done
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      poll_cnt_q  <= '0;
      poll_q      <= 1'b0;
      cap_q       <= 8'h80;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      busy_flag_q <= 1'b1;
      addr_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      bus_owned_q <= 1'b0;
      lcd_e_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      poll_cnt_q  <= poll_cnt_d;
      poll_q      <= poll_d;
      cap_q       <= cap_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      busy_flag_q <= busy_flag_d;
      addr_cnt_q  <= addr_cnt_d;
      timeout_q   <= timeout_d;
      bus_owned_q <= bus_owned_d;
      lcd_e_q     <= lcd_e_d;
    end
  end

  assign ready     = ready_q;
  assign done      = done_q;
  assign busy_flag = busy_flag_q;
  assign addr_cnt  = addr_cnt_q;
  assign timeout   = timeout_q;
  assign bus_owned = bus_owned_q;
  assign lcd_e     = lcd_e_q;
  assign lcd_rw    = bus_owned_q;
  assign lcd_rs    = 1'b0;

endmodule

// File: doc/lcd_status_reader.md
Name: lcd_status_reader

Overview:
- Read-side companion to the LCD write path: reads the HD44780 busy flag (BF) and address counter (AC) over the 4-bit LCD bus (RS=0, RW=1, two E strobes, high nibble first).
- The display block can poll BF instead of waiting fixed delays.
- Runs in the clk_disp domain beside display; the top muxes LCDE/LCDRS/LCDRW from this block whenever bus_owned=1, and releases LCDDAT drive.

Parameters:
- SETUP_CYC, 3, cycles with RS/RW valid before the first E rise (tAS >= 40 ns at 50 MHz).
- E_HIGH_CYC, 12, cycles E is held high per strobe (>= 230 ns; data sampled on the last high cycle).
- E_LOW_CYC, 13, cycles E is held low after each strobe (E cycle >= 500 ns).
- HOLD_CYC, 1, cycles RW is held high after the final E low phase before the bus is released.
- MAX_POLLS, 255, maximum reads in poll mode before timeout; 8-bit counter.

Ports:
- clk  in  1  clock (clk_disp, 50 MHz).
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  request a read; sampled only in IDLE.
- poll  in  1  sampled with start. 1 = repeat reads until BF=0.
- ready  out  1  1 in IDLE.
- done  out  1  one-cycle pulse when the transaction ends.
- busy_flag  out  1  last BF read; held until the next done.
- addr_cnt  out  7  last AC read; held until the next done.
- timeout  out  1  valid with done. 1 = poll gave up with BF still 1.
- bus_owned  out  1  1 from SETUP through HOLD. Top must tristate LCDDAT.
- lcd_e  out  1  LCD enable.
- lcd_rs  out  1  LCD register select; constant 0 (status register).
- lcd_rw  out  1  1 while bus_owned, else 0.
- lcd_dat_i  in  4  LCD data bus, read direction.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, cycle and poll counters=0.
  - Outputs: lcd_e=0, lcd_rw=0, lcd_rs=0, bus_owned=0, done=0, timeout=0, busy_flag=1 (pessimistic), addr_cnt=0, ready=1.
  - Reset mid-transaction aborts immediately; no done is issued.
- Next-state logic is registered; all outputs are decoded from state and registers (no input-to-output paths).
- FSM:
  - IDLE -> SETUP on start=1; latch poll.
  - SETUP (SETUP_CYC cycles) -> E1_HI.
  - E1_HI (E_HIGH_CYC, lcd_e=1): on the last cycle register lcd_dat_i into BF=dat[3], AC[6:4]=dat[2:0]. -> E1_LO.
  - E1_LO (E_LOW_CYC) -> E2_HI.
  - E2_HI (E_HIGH_CYC, lcd_e=1): on the last cycle register AC[3:0]=dat. -> E2_LO.
  - E2_LO (E_LOW_CYC): on the last cycle:
    - If poll latched, BF=1 and poll count < MAX_POLLS-1: increment count, go to E1_HI. RW stays high; SETUP is not repeated.
    - Otherwise go to HOLD.
  - HOLD (HOLD_CYC) -> DONE.
  - DONE (1 cycle): done=1; busy_flag and addr_cnt updated from capture registers; timeout = poll and BF and (count = MAX_POLLS-1). -> IDLE.
- Single-read latency: done is high in cycle SETUP_CYC + 2*(E_HIGH_CYC+E_LOW_CYC) + HOLD_CYC + 1 after the start-sampling edge. With defaults that is cycle 55.
- Each extra poll iteration adds 2*(E_HIGH_CYC+E_LOW_CYC) = 50 cycles.
- start outside IDLE is ignored (no queuing). start held high re-triggers on the cycle after DONE.
- The 8-bit cycle counter loads on state entry and counts down to 1. Parameters must be >= 1.
- MAX_POLLS=1 makes poll behave as a single read; timeout=BF.
- lcd_e is only asserted while bus_owned=1. lcd_rw never changes while lcd_e=1.

Test Plan:
- Single read: start=1, poll=0, lcd_dat_i=4'hA on strobe 1, 4'h5 on strobe 2 -> done at cycle 55; busy_flag=1, addr_cnt=7'h25, timeout=0; lcd_e high for exactly 12 cycles twice, separated by 13 low cycles.
- Poll success: poll=1, BF=1 on the first 3 reads, then dat=4'h0/4'h7 -> done at cycle 55+3*50=205; busy_flag=0, addr_cnt=7'h07, timeout=0.
- Poll timeout with MAX_POLLS=4: BF stuck at 1 -> exactly 4 read pairs (8 E pulses), then done with timeout=1 and busy_flag=1.
- Reset mid-op: assert rst=0 during E2_HI -> same cycle lcd_e=0, lcd_rw=0, bus_owned=0; no done pulse; after release ready=1 and busy_flag=1.
- Ignored start: pulse start during E1_LO -> no effect; exactly one done; ready rises one cycle after done.
- Timing check: assert lcd_rw=1 at least 3 cycles before each first E rise, and 1 cycle after the last E fall before bus_owned drops.
